// File: rtl/prg_loader_if.sv
// Byte-stream side (UART RX/TX pair) and memory program-port side of prg_loader.
// The master modport is the loader itself; the slave modport is its environment.
interface prg_loader_if;
    // UART receive side
    logic [7:0] rx_data;
    logic       rx_valid;

    // UART transmit side
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Memory program port
    logic       prg_clock;
    logic       prg_we;
    logic [7:0] prg_MA;
    logic [7:0] prg_WD;
    logic [7:0] prg_RD;

    // CPU reset request and status
    logic       reset_1;
    logic       overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready, prg_RD,
        output tx_data, tx_valid, prg_clock, prg_we, prg_MA, prg_WD, reset_1, overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, prg_RD,
        input  tx_data, tx_valid, prg_clock, prg_we, prg_MA, prg_WD, reset_1, overrun
    );
endinterface

// File: rtl/prg_loader.sv
// Byte-stream command engine: writes/reads CDECv memory through the prg_* port
// and drives the monitor-side CPU hold-reset. Commands are 'W' AA DD, 'R' AA,
// 'H', 'G'; anything else is answered with '?'.
module prg_loader #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int PULSE_CYCLES   = 2
) (
    input  logic         clock,
    input  logic         reset,
    prg_loader_if.master bus
);

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_H   = 8'h48;
    localparam logic [7:0] CMD_G   = 8'h47;
    localparam logic [7:0] RSP_OK  = 8'h2E;
    localparam logic [7:0] RSP_BAD = 8'h3F;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PLS_W = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        SETUP,
        CLK_HI,
        CLK_LO,
        RESP
    } state_t;

    state_t state, nxt;

    logic             is_wr;      // current command is 'W' (else 'R')
    logic [TMO_W-1:0] tmo_cnt;    // idle cycles inside a partial command
    logic [PLS_W-1:0] pulse_cnt;  // cycles spent in CLK_HI
    logic             tmo_hit;
    logic             pulse_done;
    logic             tx_fire;

    logic       prg_clock_q;
    logic       prg_we_q;
    logic [7:0] prg_ma_q;
    logic [7:0] prg_wd_q;
    logic [7:0] tx_data_q;
    logic       tx_valid_q;
    logic       reset_1_q;
    logic       overrun_q;

    assign tmo_hit    = !bus.rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign pulse_done = (pulse_cnt == PLS_W'(PULSE_CYCLES - 1));
    assign tx_fire    = tx_valid_q && bus.tx_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state decode
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_W || bus.rx_data == CMD_R) nxt = GET_ADDR;
                    else                                              nxt = RESP;
                end
            end
            GET_ADDR: begin
                if (bus.rx_valid) nxt = is_wr ? GET_DATA : SETUP;
                else if (tmo_hit) nxt = IDLE;
            end
            GET_DATA: begin
                if (bus.rx_valid) nxt = SETUP;
                else if (tmo_hit) nxt = IDLE;
            end
            SETUP:   nxt = CLK_HI;
            CLK_HI:  if (pulse_done) nxt = CLK_LO;
            CLK_LO:  nxt = RESP;
            RESP:    if (tx_fire) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Partial-command timeout: counts cycles without a byte while collecting operands
    always_ff @(posedge clock) begin
        if (reset)
            tmo_cnt <= '0;
        else if ((state == GET_ADDR || state == GET_DATA) && !bus.rx_valid)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end

    // Width of the prg_clock high phase
    always_ff @(posedge clock) begin
        if (reset)                pulse_cnt <= '0;
        else if (state == CLK_HI) pulse_cnt <= pulse_cnt + 1'b1;
        else                      pulse_cnt <= '0;
    end

    // Datapath: program port, response byte, reset_1 and overrun flag
    always_ff @(posedge clock) begin
        if (reset) begin
            is_wr       <= 1'b0;
            prg_clock_q <= 1'b0;
            prg_we_q    <= 1'b0;
            prg_ma_q    <= '0;
            prg_wd_q    <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            reset_1_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Registered from next state so the pulse is glitch-free and
            // high exactly while the FSM sits in CLK_HI.
            prg_clock_q <= (nxt == CLK_HI);
            tx_valid_q  <= (nxt == RESP);
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        is_wr <= (bus.rx_data == CMD_W);
                        case (bus.rx_data)
                            CMD_W, CMD_R: ;
                            CMD_H: begin
                                reset_1_q <= 1'b1;
                                tx_data_q <= RSP_OK;
                            end
                            CMD_G: begin
                                reset_1_q <= 1'b0;
                                tx_data_q <= RSP_OK;
                            end
                            default: tx_data_q <= RSP_BAD;
                        endcase
                    end
                end
                GET_ADDR: begin
                    if (bus.rx_valid) begin
                        prg_ma_q <= bus.rx_data;
                        prg_we_q <= 1'b0;
                    end
                end
                GET_DATA: begin
                    if (bus.rx_valid) begin
                        prg_wd_q <= bus.rx_data;
                        prg_we_q <= 1'b1;
                    end else if (tmo_hit) begin
                        prg_we_q <= 1'b0;
                    end
                end
                CLK_LO: begin
                    prg_we_q  <= 1'b0;
                    tx_data_q <= is_wr ? RSP_OK : bus.prg_RD;
                    if (bus.rx_valid) overrun_q <= 1'b1;
                end
                SETUP, CLK_HI, RESP: begin
                    // Busy: the byte is dropped, including one arriving
                    // in the same cycle the response is accepted.
                    if (bus.rx_valid) overrun_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.prg_clock = prg_clock_q;
    assign bus.prg_we    = prg_we_q;
    assign bus.prg_MA    = prg_ma_q;
    assign bus.prg_WD    = prg_wd_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.reset_1   = reset_1_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader with a 256-byte memory model on the program port.
module tb_prg_loader;
    localparam int TMO = 16;
    localparam int PLS = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    prg_loader_if bus();

    prg_loader #(.TIMEOUT_CYCLES(TMO), .PULSE_CYCLES(PLS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Memory model: acts on the rising edge of prg_clock
    logic [7:0] mem [256];
    logic [7:0] rd_q;
    int wr_pulses = 0;
    int rd_pulses = 0;
    logic last_we;

    always @(posedge bus.prg_clock) begin
        last_we = bus.prg_we;
        if (bus.prg_we) begin
            mem[bus.prg_MA] = bus.prg_WD;
            wr_pulses++;
        end else begin
            rd_pulses++;
        end
        rd_q = mem[bus.prg_MA];
    end
    assign bus.prg_RD = rd_q;

    // Pulse width and program-port stability monitor
    int hi_run = 0;
    int last_width = 0;
    int viol = 0;
    logic prev_clk = 1'b0;
    logic prev_we = 1'b0;

    always @(negedge clock) begin
        if (bus.prg_clock === 1'b1) begin
            hi_run++;
        end else begin
            if (hi_run != 0) last_width = hi_run;
            hi_run = 0;
        end
        if (prev_clk === 1'b1 && bus.prg_clock === 1'b1 && bus.prg_we !== prev_we) viol++;
        if (bus.prg_clock === 1'b1 && bus.tx_valid === 1'b1) viol++;
        prev_clk = bus.prg_clock;
        prev_we  = bus.prg_we;
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clock); #1;
        bus.rx_valid = 1'b0;
    endtask

    // Cycles from the edge that sampled the last byte (counted as 1) to tx_valid
    task automatic wait_tx(output int n);
        n = 1;
        while (bus.tx_valid !== 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (bus.tx_valid !== 1'b1) n = -1;
    endtask

    task automatic accept_tx();
        bus.tx_ready = 1'b1;
        @(posedge clock); #1;
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if ({bus.prg_clock, bus.prg_we, bus.prg_MA, bus.prg_WD, bus.tx_data,
             bus.tx_valid, bus.reset_1, bus.overrun} !== 35'h0) begin
            fails++;
            $display("FAIL reset_outputs: got clk=%b we=%b MA=%h WD=%h tx=%h v=%b r1=%b ov=%b, want all 0",
                     bus.prg_clock, bus.prg_we, bus.prg_MA, bus.prg_WD, bus.tx_data,
                     bus.tx_valid, bus.reset_1, bus.overrun);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_write();
        int n;
        int w0;
        w0 = wr_pulses;
        send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
        wait_tx(n);
        tests++;
        if (n !== PLS + 3) begin fails++; $display("FAIL write_latency: got %0d want %0d", n, PLS + 3); end
        tests++;
        if (bus.tx_data !== 8'h2E) begin fails++; $display("FAIL write_reply: got %h want 2e", bus.tx_data); end
        tests++;
        if (wr_pulses !== w0 + 1) begin fails++; $display("FAIL write_pulses: got %0d want %0d", wr_pulses, w0 + 1); end
        tests++;
        if (last_width !== PLS) begin fails++; $display("FAIL write_pulse_width: got %0d want %0d", last_width, PLS); end
        tests++;
        if (last_we !== 1'b1) begin fails++; $display("FAIL write_we_at_pulse: got %b want 1", last_we); end
        tests++;
        if (mem[8'h10] !== 8'hA5) begin fails++; $display("FAIL write_mem: got %h want a5", mem[8'h10]); end
        tests++;
        if ({bus.prg_MA, bus.prg_WD, bus.prg_we} !== {8'h10, 8'hA5, 1'b0}) begin
            fails++;
            $display("FAIL write_port_hold: got MA=%h WD=%h we=%b want 10 a5 0", bus.prg_MA, bus.prg_WD, bus.prg_we);
        end
        accept_tx();
        tests++;
        if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL write_accept: tx_valid got %b want 0", bus.tx_valid); end
    endtask

    task automatic test_read();
        int n;
        int w0;
        int r0;
        w0 = wr_pulses;
        r0 = rd_pulses;
        send_byte(8'h52); send_byte(8'h10);
        wait_tx(n);
        tests++;
        if (n !== PLS + 3) begin fails++; $display("FAIL read_latency: got %0d want %0d", n, PLS + 3); end
        tests++;
        if (bus.tx_data !== 8'hA5) begin fails++; $display("FAIL read_data: got %h want a5", bus.tx_data); end
        tests++;
        if (wr_pulses !== w0 || rd_pulses !== r0 + 1) begin
            fails++;
            $display("FAIL read_pulses: got wr=%0d rd=%0d want wr=%0d rd=%0d", wr_pulses, rd_pulses, w0, r0 + 1);
        end
        accept_tx();
        // Untouched location holds its preset pattern (~addr)
        send_byte(8'h52); send_byte(8'h33);
        wait_tx(n);
        tests++;
        if (bus.tx_data !== 8'hCC) begin fails++; $display("FAIL read_preset: got %h want cc", bus.tx_data); end
        accept_tx();
    endtask

    task automatic test_hold_go_unknown();
        int n;
        send_byte(8'h48);
        tests++;
        if (bus.reset_1 !== 1'b1) begin fails++; $display("FAIL hold_reset_1: got %b want 1", bus.reset_1); end
        wait_tx(n);
        tests++;
        if (bus.tx_data !== 8'h2E) begin fails++; $display("FAIL hold_reply: got %h want 2e", bus.tx_data); end
        accept_tx();
        send_byte(8'h00);
        wait_tx(n);
        tests++;
        if (bus.tx_data !== 8'h3F || bus.reset_1 !== 1'b1) begin
            fails++;
            $display("FAIL unknown_cmd: got tx=%h r1=%b want 3f 1", bus.tx_data, bus.reset_1);
        end
        accept_tx();
        send_byte(8'h47);
        wait_tx(n);
        tests++;
        if (bus.tx_data !== 8'h2E || bus.reset_1 !== 1'b0) begin
            fails++;
            $display("FAIL go_cmd: got tx=%h r1=%b want 2e 0", bus.tx_data, bus.reset_1);
        end
        accept_tx();
    endtask

    task automatic test_timeout();
        int n;
        int w0;
        int r0;
        w0 = wr_pulses;
        r0 = rd_pulses;
        send_byte(8'h57); send_byte(8'h10);
        repeat (TMO + 1) @(posedge clock);
        #1;
        tests++;
        if (bus.tx_valid !== 1'b0 || bus.prg_we !== 1'b0) begin
            fails++;
            $display("FAIL timeout_abort: got tx_valid=%b we=%b want 0 0", bus.tx_valid, bus.prg_we);
        end
        send_byte(8'h52); send_byte(8'h10);
        wait_tx(n);
        tests++;
        if (n !== PLS + 3 || bus.tx_data !== 8'hA5) begin
            fails++;
            $display("FAIL timeout_then_read: got n=%0d tx=%h want %0d a5", n, bus.tx_data, PLS + 3);
        end
        tests++;
        if (wr_pulses !== w0 || rd_pulses !== r0 + 1) begin
            fails++;
            $display("FAIL timeout_pulses: got wr=%0d rd=%0d want wr=%0d rd=%0d", wr_pulses, rd_pulses, w0, r0 + 1);
        end
        accept_tx();
        // One idle cycle short of the limit: command must still complete
        send_byte(8'h57); send_byte(8'h20);
        repeat (TMO - 1) @(posedge clock);
        #1;
        send_byte(8'h5C);
        wait_tx(n);
        tests++;
        if (n !== PLS + 3 || mem[8'h20] !== 8'h5C) begin
            fails++;
            $display("FAIL timeout_boundary: got n=%0d mem=%h want %0d 5c", n, mem[8'h20], PLS + 3);
        end
        accept_tx();
    endtask

    task automatic test_back_to_back();
        int n;
        send_byte(8'h48);
        wait_tx(n);
        // Byte arriving with the acceptance is dropped
        bus.tx_ready = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b1;
        @(posedge clock); #1;
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if (bus.tx_valid !== 1'b0 || bus.reset_1 !== 1'b1) begin
            fails++;
            $display("FAIL accept_drop: got tx_valid=%b r1=%b want 0 1", bus.tx_valid, bus.reset_1);
        end
        send_byte(8'h57); send_byte(8'h77); send_byte(8'h3C);
        wait_tx(n);
        accept_tx();
        send_byte(8'h52); send_byte(8'h77);
        wait_tx(n);
        tests++;
        if (bus.tx_data !== 8'h3C) begin fails++; $display("FAIL b2b_read: got %h want 3c", bus.tx_data); end
        accept_tx();
    endtask

    task automatic test_backpressure();
        int n;
        int unstable;
        tests++;
        if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_prior: got %b want 1", bus.overrun); end
        send_byte(8'h52); send_byte(8'h33);
        wait_tx(n);
        unstable = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                bus.rx_data  = 8'h55;
                bus.rx_valid = 1'b1;
            end
            @(posedge clock); #1;
            bus.rx_valid = 1'b0;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hCC) unstable++;
        end
        tests++;
        if (unstable !== 0) begin fails++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
        accept_tx();
        send_byte(8'h47);
        wait_tx(n);
        tests++;
        if (n !== 1 || bus.tx_data !== 8'h2E || bus.reset_1 !== 1'b0) begin
            fails++;
            $display("FAIL bp_next_cmd: got n=%0d tx=%h r1=%b want 1 2e 0", n, bus.tx_data, bus.reset_1);
        end
        accept_tx();
    endtask

    task automatic test_reset_mid_op();
        int n;
        send_byte(8'h48);
        wait_tx(n);
        accept_tx();
        send_byte(8'h57); send_byte(8'h44); send_byte(8'h99);
        n = 0;
        while (bus.prg_clock !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        tests++;
        if (bus.prg_clock !== 1'b1) begin fails++; $display("FAIL midop_reach_clk_hi: got %b want 1", bus.prg_clock); end
        reset = 1'b1;
        @(posedge clock); #1;
        tests++;
        if ({bus.prg_clock, bus.prg_we, bus.prg_MA, bus.prg_WD, bus.tx_data,
             bus.tx_valid, bus.reset_1, bus.overrun} !== 35'h0) begin
            fails++;
            $display("FAIL midop_reset: got clk=%b we=%b MA=%h WD=%h tx=%h v=%b r1=%b ov=%b, want all 0",
                     bus.prg_clock, bus.prg_we, bus.prg_MA, bus.prg_WD, bus.tx_data,
                     bus.tx_valid, bus.reset_1, bus.overrun);
        end
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        tests++;
        if (bus.tx_valid !== 1'b0 || bus.prg_clock !== 1'b0) begin
            fails++;
            $display("FAIL midop_quiet: got tx_valid=%b clk=%b want 0 0", bus.tx_valid, bus.prg_clock);
        end
        send_byte(8'h47);
        wait_tx(n);
        tests++;
        if (n !== 1 || bus.tx_data !== 8'h2E) begin
            fails++;
            $display("FAIL midop_recover: got n=%0d tx=%h want 1 2e", n, bus.tx_data);
        end
        accept_tx();
    endtask

    task automatic test_invariants();
        tests++;
        if (viol !== 0) begin fails++; $display("FAIL port_invariants: got %0d violations want 0", viol); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ~(8'(i));
        rd_q         = 8'h00;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        #1;
        test_reset();
        test_write();
        test_read();
        test_hold_go_unknown();
        test_timeout();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
